// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - FIFO-fed JK register driver computing per-bit J/K excitation toward queued targets
// Define JK_TOGGLE_EN to resolve excitation don't-cares as toggles (J=K=1 on changing bits).
module jk_excite_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tgt_valid,
  output logic                     tgt_ready,
  input  logic [WIDTH-1:0]         tgt_data,
  input  logic                     hold,
  output logic [WIDTH-1:0]         j_out,
  output logic [WIDTH-1:0]         k_out,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_bar,
  output logic                     upd_valid,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [CNT_W-1:0]         flip_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PC_W = $clog2(WIDTH + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  logic [WIDTH-1:0] q_next;
  logic [PC_W-1:0]  pc;
  logic [CNT_W:0]   flip_sum;
  logic [CNT_W-1:0] flip_next;

  // No look-ahead on a same-edge pop: a full FIFO always refuses.
  assign tgt_ready = (fifo_cnt < FULL);
  assign push      = tgt_valid && tgt_ready;
  assign pop       = (fifo_cnt != '0) && !hold;
  assign head      = mem[rd_ptr];
  assign diff      = q ^ head;
  assign q_bar     = ~q;

  always_comb begin
    j_next = '0;
    k_next = '0;
`ifdef JK_TOGGLE_EN
    j_next = diff;
    k_next = diff;
`else
    j_next = ~q & head;
    k_next = q & ~head;
`endif
  end

  // JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j_next[i], k_next[i]})
        2'b01:   q_next[i] = 1'b0;
        2'b10:   q_next[i] = 1'b1;
        2'b11:   q_next[i] = ~q[i];
        default: q_next[i] = q[i];
      endcase
    end
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PC_W'(diff[i]);
    end
    flip_sum  = {1'b0, flip_cnt} + (CNT_W + 1)'(pc);
    flip_next = flip_sum[CNT_W] ? {CNT_W{1'b1}} : flip_sum[CNT_W-1:0];
  end

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tgt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      q         <= '0;
      j_out     <= '0;
      k_out     <= '0;
      upd_valid <= 1'b0;
      flip_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (pop) begin
        q         <= q_next;
        j_out     <= j_next;
        k_out     <= k_next;
        upd_valid <= 1'b1;
        flip_cnt  <= flip_next;
      end else begin
        j_out     <= '0;
        k_out     <= '0;
        upd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// tb/tb_jk_excite_driver.sv - directed self-checking bench for jk_excite_driver
module tb_jk_excite_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_data;
  logic       hold;
  logic [7:0] j_out, k_out, q, q_bar;
  logic       upd_valid;
  logic [2:0] fifo_cnt;
  logic [15:0] flip_cnt;

  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_hold;
  logic [7:0] s_j, s_k, s_q, s_qb;
  logic       s_upd;
  logic [2:0] s_cnt;
  logic [3:0] s_flip;

  int total = 0;
  int bad   = 0;

  jk_excite_driver #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_data(tgt_data), .hold(hold), .j_out(j_out), .k_out(k_out),
    .q(q), .q_bar(q_bar), .upd_valid(upd_valid), .fifo_cnt(fifo_cnt),
    .flip_cnt(flip_cnt)
  );

  jk_excite_driver #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .tgt_valid(s_valid), .tgt_ready(s_ready),
    .tgt_data(s_data), .hold(s_hold), .j_out(s_j), .k_out(s_k),
    .q(s_q), .q_bar(s_qb), .upd_valid(s_upd), .fifo_cnt(s_cnt),
    .flip_cnt(s_flip)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; tgt_valid = 1'b0; tgt_data = '0; hold = 1'b0;
    s_valid = 1'b0; s_data = '0; s_hold = 1'b0;
    tick; tick;
    rst = 1'b0;
    check("rst_q", q, 8'h00);
    check("rst_qbar", q_bar, 8'hFF);
    check("rst_j", j_out, 8'h00);
    check("rst_k", k_out, 8'h00);
    check("rst_upd", upd_valid, 1'b0);
    check("rst_cnt", fifo_cnt, 3'd0);
    check("rst_flip", flip_cnt, 16'd0);
    check("rst_ready", tgt_ready, 1'b1);

    // basic step 0x00 -> 0xA5
    tgt_valid = 1'b1; tgt_data = 8'hA5;
    tick;
    tgt_valid = 1'b0;
    check("push_cnt", fifo_cnt, 3'd1);
    check("push_upd", upd_valid, 1'b0);
    tick;
    check("basic_q", q, 8'hA5);
    check("basic_qbar", q_bar, 8'h5A);
    check("basic_upd", upd_valid, 1'b1);
    check("basic_flip", flip_cnt, 16'd4);
    check("basic_cnt", fifo_cnt, 3'd0);
`ifdef JK_TOGGLE_EN
    check("basic_j", j_out, 8'hA5);
    check("basic_k", k_out, 8'hA5);
`else
    check("basic_j", j_out, 8'hA5);
    check("basic_k", k_out, 8'h00);
`endif

    // excitation 0xA5 -> 0x3C
    tgt_valid = 1'b1; tgt_data = 8'h3C;
    tick;
    tgt_valid = 1'b0;
    tick;
    check("exc_q", q, 8'h3C);
    check("exc_flip", flip_cnt, 16'd8);
`ifdef JK_TOGGLE_EN
    check("exc_j", j_out, 8'h99);
    check("exc_k", k_out, 8'h99);
`else
    check("exc_j", j_out, 8'h18);
    check("exc_k", k_out, 8'h81);
`endif
    tick;
    check("idle_upd", upd_valid, 1'b0);
    check("idle_j", j_out, 8'h00);
    check("idle_k", k_out, 8'h00);

    // FIFO fill under hold, then drain
    hold = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      tgt_valid = 1'b1; tgt_data = 8'(v);
      tick;
    end
    tgt_valid = 1'b0;
    check("fill_cnt", fifo_cnt, 3'd4);
    check("fill_ready", tgt_ready, 1'b0);
    check("hold_q", q, 8'h3C);
    check("hold_upd", upd_valid, 1'b0);
    tgt_valid = 1'b1; tgt_data = 8'h05;
    tick;
    tgt_valid = 1'b0;
    check("full_cnt", fifo_cnt, 3'd4);
    hold = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      tick;
      check($sformatf("drain_q%0d", v), q, 32'(v));
      check($sformatf("drain_cnt%0d", v), fifo_cnt, 32'(4 - v));
      check($sformatf("drain_upd%0d", v), upd_valid, 1'b1);
    end
    check("drain_flip", flip_cnt, 16'd19);
    tick;
    check("drain_end_q", q, 8'h04);
    check("drain_end_upd", upd_valid, 1'b0);
    check("drain_ready", tgt_ready, 1'b1);

    // back-to-back stream from reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tgt_valid = 1'b1; tgt_data = 8'h00;
    tick;
    tgt_data = 8'hFF;
    tick;
    check("b2b_q0", q, 8'h00);
    check("b2b_upd0", upd_valid, 1'b1);
    tgt_data = 8'h00;
    tick;
    check("b2b_q1", q, 8'hFF);
    check("b2b_upd1", upd_valid, 1'b1);
    tgt_data = 8'hFF;
    tick;
    tgt_valid = 1'b0;
    check("b2b_q2", q, 8'h00);
    check("b2b_upd2", upd_valid, 1'b1);
    check("b2b_cnt2", fifo_cnt, 3'd1);
    tick;
    check("b2b_q3", q, 8'hFF);
    check("b2b_upd3", upd_valid, 1'b1);
    check("b2b_flip", flip_cnt, 16'd24);
    check("b2b_cnt3", fifo_cnt, 3'd0);

    // reset with pending entries
    tgt_valid = 1'b1; tgt_data = 8'h55;
    tick;
    tgt_valid = 1'b0;
    tick;
    check("pre_rst_q", q, 8'h55);
    hold = 1'b1;
    tgt_valid = 1'b1; tgt_data = 8'hAA; tick;
    tgt_data = 8'hBB; tick;
    tgt_data = 8'hCC; tick;
    tgt_valid = 1'b0;
    check("pre_rst_cnt", fifo_cnt, 3'd3);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    hold = 1'b0;
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_cnt", fifo_cnt, 3'd0);
    check("mid_rst_flip", flip_cnt, 16'd0);
    check("mid_rst_j", j_out, 8'h00);
    check("mid_rst_k", k_out, 8'h00);
    check("mid_rst_ready", tgt_ready, 1'b1);
    tick; tick;
    check("post_rst_q", q, 8'h00);
    check("post_rst_upd", upd_valid, 1'b0);

    // saturation on the 4-bit counter instance
    s_valid = 1'b1; s_data = 8'hFF;
    tick;
    s_data = 8'h00;
    tick;
    check("sat_q0", s_q, 8'hFF);
    check("sat_flip0", s_flip, 4'd8);
    s_data = 8'hFF;
    tick;
    check("sat_q1", s_q, 8'h00);
    check("sat_flip1", s_flip, 4'd15);
    s_data = 8'h00;
    tick;
    s_valid = 1'b0;
    check("sat_q2", s_q, 8'hFF);
    check("sat_flip2", s_flip, 4'd15);
    tick;
    check("sat_q3", s_q, 8'h00);
    check("sat_flip3", s_flip, 4'd15);
    check("sat_upd3", s_upd, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
